// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one pipeline stage: upstream (in_*) and downstream (out_*) sides.
// The stage side uses the slave modport. The surrounding pipeline uses the master modport.
interface pipe_stage_skid_if #(
   parameter int DATA_W = 197,
   parameter int CTRL_W = 9
);
   // valid/ready: a transfer happens on a rising clock edge where valid and ready are both 1.
   // A source keeps valid and its payload stable until the transfer.
   // ready never depends combinationally on valid.
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;

   modport master (
      output in_valid, in_data, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl
   );

   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_ctrl
   );
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer, synchronous flush and a stall counter.
// The state is {main_v, skid_v} and is visible on the occupancy output: EMPTY, ONE or FULL.
module pipe_stage_skid #(
   parameter int DATA_W = 197,
   parameter int CTRL_W = 9,
   parameter int CNT_W  = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                flush,
   pipe_stage_skid_if.slave    bus,
   output logic [1:0]          occupancy,
   output logic [CNT_W-1:0]    stall_cnt
);

   logic [DATA_W-1:0] main_data, main_data_n, skid_data, skid_data_n;
   logic [CTRL_W-1:0] main_ctrl, main_ctrl_n, skid_ctrl, skid_ctrl_n;
   logic              main_v, main_v_n, skid_v, skid_v_n;
   logic [CNT_W-1:0]  stall_cnt_n;
   logic              in_fire, out_fire;

   assign in_fire  = bus.in_valid & ~skid_v;
   assign out_fire = main_v & bus.out_ready;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         main_data <= '0;
         main_ctrl <= '0;
         main_v    <= 1'b0;
         skid_data <= '0;
         skid_ctrl <= '0;
         skid_v    <= 1'b0;
         stall_cnt <= '0;
      end else begin
         main_data <= main_data_n;
         main_ctrl <= main_ctrl_n;
         main_v    <= main_v_n;
         skid_data <= skid_data_n;
         skid_ctrl <= skid_ctrl_n;
         skid_v    <= skid_v_n;
         stall_cnt <= stall_cnt_n;
      end
   end

   // Next state
   always_comb begin
      main_data_n = main_data;
      main_ctrl_n = main_ctrl;
      main_v_n    = main_v;
      skid_data_n = skid_data;
      skid_ctrl_n = skid_ctrl;
      skid_v_n    = skid_v;
      stall_cnt_n = stall_cnt;

      // The counter is independent of flush. It saturates instead of wrapping.
      if (main_v && !bus.out_ready && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt_n = stall_cnt + 1'b1;

      if (flush) begin
         main_v_n    = 1'b0;
         skid_v_n    = 1'b0;
         main_ctrl_n = '0;
         skid_ctrl_n = '0;
      end else begin
         unique case ({main_v, skid_v})
            2'b00: begin
               if (in_fire) begin
                  main_data_n = bus.in_data;
                  main_ctrl_n = bus.in_ctrl;
                  main_v_n    = 1'b1;
               end
            end
            2'b10: begin
               if (in_fire && out_fire) begin
                  main_data_n = bus.in_data;
                  main_ctrl_n = bus.in_ctrl;
               end else if (in_fire) begin
                  skid_data_n = bus.in_data;
                  skid_ctrl_n = bus.in_ctrl;
                  skid_v_n    = 1'b1;
               end else if (out_fire) begin
                  main_v_n = 1'b0;
               end
            end
            2'b11: begin
               if (out_fire) begin
                  main_data_n = skid_data;
                  main_ctrl_n = skid_ctrl;
                  skid_v_n    = 1'b0;
               end
            end
            default: begin
               // A skid entry without a main entry cannot be reached. Recover to EMPTY.
               main_v_n = 1'b0;
               skid_v_n = 1'b0;
            end
         endcase
      end
   end

   // Outputs
   always_comb begin
      bus.in_ready  = ~skid_v;
      bus.out_valid = main_v;
      bus.out_data  = main_data;
      bus.out_ctrl  = main_v ? main_ctrl : '0;
      occupancy     = {1'b0, main_v} + {1'b0, skid_v};
   end

endmodule
